// File: rtl/ext_power_domain_ctrl_pkg.sv
// Shared types for the external power domain controller.
// Holds the sequencing states, status encoding and output decode.
package ext_power_domain_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_ON,
        ST_OFF_CLK,
        ST_OFF_ISO,
        ST_OFF_RST,
        ST_OFF_SW,
        ST_OFF,
        ST_ON_SW,
        ST_ON_CLK,
        ST_ON_RST,
        ST_ON_ISO
    } pd_state_e;

    localparam logic [1:0] STATUS_ON    = 2'b00;
    localparam logic [1:0] STATUS_OFF   = 2'b01;
    localparam logic [1:0] STATUS_TRANS = 2'b10;

    typedef struct packed {
        logic       switch_n;
        logic       iso_n;
        logic       rst_n;
        logic       clkgate_en_n;
        logic       busy;
        logic [1:0] status;
    } pd_out_t;

    // Start from the fully-on pattern and strip controls per state.
    function automatic pd_out_t pd_decode(pd_state_e st);
        pd_out_t o;
        o.switch_n     = 1'b0;
        o.iso_n        = 1'b1;
        o.rst_n        = 1'b1;
        o.clkgate_en_n = 1'b1;
        o.busy         = 1'b1;
        o.status       = STATUS_TRANS;
        case (st)
            ST_ON: begin
                o.busy   = 1'b0;
                o.status = STATUS_ON;
            end
            ST_OFF_CLK: begin
                o.clkgate_en_n = 1'b0;
            end
            ST_OFF_ISO: begin
                o.clkgate_en_n = 1'b0;
                o.iso_n        = 1'b0;
            end
            ST_OFF_RST, ST_ON_SW: begin
                o.clkgate_en_n = 1'b0;
                o.iso_n        = 1'b0;
                o.rst_n        = 1'b0;
            end
            ST_OFF_SW: begin
                o.clkgate_en_n = 1'b0;
                o.iso_n        = 1'b0;
                o.rst_n        = 1'b0;
                o.switch_n     = 1'b1;
            end
            ST_OFF: begin
                o.clkgate_en_n = 1'b0;
                o.iso_n        = 1'b0;
                o.rst_n        = 1'b0;
                o.switch_n     = 1'b1;
                o.busy         = 1'b0;
                o.status       = STATUS_OFF;
            end
            ST_ON_CLK: begin
                o.iso_n = 1'b0;
                o.rst_n = 1'b0;
            end
            ST_ON_RST: begin
                o.iso_n = 1'b0;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ext_power_domain_ctrl_if.sv
// Request, switch-ack and domain control bundle.
// master = system side, slave = power controller.
interface ext_power_domain_ctrl_if;

    logic       power_off_req_i;
    logic       power_on_req_i;
    logic       switch_ack_ni;
    logic       switch_no;
    logic       iso_no;
    logic       rst_no;
    logic       clkgate_en_no;
    logic       busy_o;
    logic [1:0] status_o;
    logic       timeout_o;

    modport master (
        output power_off_req_i,
        output power_on_req_i,
        output switch_ack_ni,
        input  switch_no,
        input  iso_no,
        input  rst_no,
        input  clkgate_en_no,
        input  busy_o,
        input  status_o,
        input  timeout_o
    );

    modport slave (
        input  power_off_req_i,
        input  power_on_req_i,
        input  switch_ack_ni,
        output switch_no,
        output iso_no,
        output rst_no,
        output clkgate_en_no,
        output busy_o,
        output status_o,
        output timeout_o
    );

endinterface

// File: rtl/ext_pwr_ack_sync.sv
// Two-flop synchronizer for the asynchronous switch-cell acknowledge.
module ext_pwr_ack_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/ext_power_domain_ctrl.sv
// External power domain sequencer: ordered clock/iso/reset/switch
// control with switch-ack wait and sticky ack timeout.
module ext_power_domain_ctrl
    import ext_power_domain_ctrl_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input logic               clk_i,
    input logic               rst_ni,
    ext_power_domain_ctrl_if.slave pd
);

    localparam int unsigned CNT_MAX =
        (STEP_CYCLES > ACK_TIMEOUT) ? STEP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    pd_state_e        state_q;
    pd_state_e        state_d;
    pd_out_t          out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             accept;
    logic             step_done;
    logic             wait_st;
    logic             ack_sync;

    ext_pwr_ack_sync #(
        .RST_VAL(1'b0)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (pd.switch_ack_ni),
        .q_o   (ack_sync)
    );

    assign step_done = (cnt_q == STEP_LAST);
    assign wait_st   = (state_q == ST_OFF_SW) || (state_q == ST_ON_SW);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_ON: begin
                if (pd.power_off_req_i) begin
                    state_d = ST_OFF_CLK;
                    accept  = 1'b1;
                end
            end
            ST_OFF_CLK: if (step_done) state_d = ST_OFF_ISO;
            ST_OFF_ISO: if (step_done) state_d = ST_OFF_RST;
            ST_OFF_RST: if (step_done) state_d = ST_OFF_SW;
            ST_OFF_SW:  if (ack_sync)  state_d = ST_OFF;
            ST_OFF: begin
                if (pd.power_on_req_i) begin
                    state_d = ST_ON_SW;
                    accept  = 1'b1;
                end
            end
            ST_ON_SW:  if (!ack_sync) state_d = ST_ON_CLK;
            ST_ON_CLK: if (step_done) state_d = ST_ON_RST;
            ST_ON_RST: if (step_done) state_d = ST_ON_ISO;
            ST_ON_ISO: if (step_done) state_d = ST_ON;
            default:   state_d = ST_ON;
        endcase
    end

    // Outputs are registered from the next state so they change in
    // lockstep with the state register and never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ON;
            out_q     <= pd_decode(ST_ON);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= pd_decode(state_d);
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (wait_st && (state_d == state_q)
                         && (cnt_q == TO_LAST)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign pd.switch_no     = out_q.switch_n;
    assign pd.iso_no        = out_q.iso_n;
    assign pd.rst_no        = out_q.rst_n;
    assign pd.clkgate_en_no = out_q.clkgate_en_n;
    assign pd.busy_o        = out_q.busy;
    assign pd.status_o      = out_q.status;
    assign pd.timeout_o     = timeout_q;

endmodule

// File: tb/tb_ext_power_domain_ctrl.sv
// Bench for ext_power_domain_ctrl: switch ack modelled as switch_no
// delayed 15 cycles; outputs compared against an event-time model.
module tb_ext_power_domain_ctrl;
    import ext_power_domain_ctrl_pkg::*;

    localparam int S   = 2;
    localparam int TO  = 64;
    localparam int DLY = 15;
    localparam int INF = 1 << 30;
    localparam logic [7:0] RST_EXP = 8'b0111_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ext_power_domain_ctrl_if pd();

    ext_power_domain_ctrl #(
        .STEP_CYCLES(S),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .pd    (pd)
    );

    always #5 clk = ~clk;

    logic [DLY-1:0] hist      = '0;
    logic           ack_dly   = 1'b0;
    logic           ack_force = 1'b0;

    always @(negedge clk) begin
        ack_dly <= hist[DLY-1];
        hist    <= {hist[DLY-2:0], pd.switch_no};
    end

    assign pd.switch_ack_ni = ack_force | ack_dly;

    // Model: current sequence direction (0 none, 1 down, 2 up),
    // its first cycle, and the cycle the switch ack changes.
    int m_dir = 0;
    int m_s   = 0;
    int m_a   = 0;

    function automatic bit model_on(int n);
        return (m_dir == 0) || (m_dir == 2 && n >= m_a + 3 + 3 * S);
    endfunction

    function automatic bit model_off(int n);
        return (m_dir == 1) && (n >= m_a + 3);
    endfunction

    function automatic logic [7:0] exp_out(int n);
        logic sw, iso, rn, ck, bz, to;
        logic [1:0] st;
        int w;
        sw = 0; iso = 1; rn = 1; ck = 1; bz = 0; st = STATUS_ON;
        if (m_dir == 1) begin
            if (n >= m_a + 3) begin
                sw = 1; iso = 0; rn = 0; ck = 0; st = STATUS_OFF;
            end else begin
                sw  = (n >= m_s + 3 * S);
                ck  = 0;
                iso = !(n >= m_s + S);
                rn  = !(n >= m_s + 2 * S);
                bz  = 1; st = STATUS_TRANS;
            end
        end else if (m_dir == 2 && n < m_a + 3 + 3 * S) begin
            ck  = (n >= m_a + 3);
            rn  = (n >= m_a + 3 + S);
            iso = (n >= m_a + 3 + 2 * S);
            bz  = 1; st = STATUS_TRANS;
        end
        w  = (m_dir == 1) ? m_s + 3 * S : m_s;
        to = (m_dir != 0) && (w + TO <= n) && (w + TO <= m_a + 2);
        return {sw, iso, rn, ck, bz, st, to};
    endfunction

    function automatic logic [7:0] obs();
        return {pd.switch_no, pd.iso_no, pd.rst_no, pd.clkgate_en_no,
                pd.busy_o, pd.status_o, pd.timeout_o};
    endfunction

    task automatic model_req(int n, bit off, bit on);
        if (model_on(n) && off) begin
            m_dir = 1; m_s = n + 1; m_a = m_s + 3 * S + DLY;
        end else if (model_off(n) && on) begin
            m_dir = 2; m_s = n + 1;
            m_a = ack_force ? INF : m_s + DLY;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        pd.power_off_req_i = 1'b0;
        pd.power_on_req_i  = 1'b0;
    endtask

    task automatic test_reset();
        pd.power_off_req_i = 1'b0;
        pd.power_on_req_i  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs() !== RST_EXP) begin
            errors++;
            $display("FAIL reset got %b exp %b", obs(), RST_EXP);
        end
        rst_n = 1'b1;
        m_dir = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
        end
    endtask

    task automatic test_power_down();
        int c, t_off;
        t_off = -1;
        tick();
        c = cyc;
        pd.power_off_req_i = 1'b1;
        model_req(c, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL power_down cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (t_off < 0 && pd.status_o == STATUS_OFF) t_off = cyc;
        end
        checks++;
        if (t_off != c + 25) begin
            errors++;
            $display("FAIL off_latency got %0d exp %0d", t_off - c, 25);
        end
    endtask

    task automatic test_power_up();
        int c, t_clk, t_on;
        t_clk = -1;
        t_on  = -1;
        tick();
        c = cyc;
        pd.power_on_req_i = 1'b1;
        model_req(c, 1'b0, 1'b1);
        for (int k = 0; k < 35; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL power_up cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (t_clk < 0 && pd.clkgate_en_no === 1'b1) t_clk = cyc;
            if (t_on < 0 && pd.status_o == STATUS_ON) t_on = cyc;
        end
        checks++;
        if (t_clk != c + 1 + DLY + 3 || t_on != t_clk + 3 * S) begin
            errors++;
            $display("FAIL on_latency got clk %0d on %0d exp %0d %0d",
                     t_clk - c, t_on - c, 1 + DLY + 3, 1 + DLY + 3 + 3 * S);
        end
    endtask

    task automatic test_ignored();
        int c;
        tick();
        c = cyc;
        pd.power_off_req_i = 1'b1;
        model_req(c, 1'b1, 1'b0);
        for (int k = 0; k < 70; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL ignored cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (cyc == c + 1 + S) begin
                pd.power_off_req_i = 1'b1;
                model_req(cyc, 1'b1, 1'b0);
            end
            if (cyc == c + 1 + 3 * S + 3) begin
                pd.power_on_req_i = 1'b1;
                model_req(cyc, 1'b0, 1'b1);
            end
            if (cyc == c + 30) begin
                pd.power_on_req_i = 1'b1;
                model_req(cyc, 1'b0, 1'b1);
            end
        end
        tick();
        c = cyc;
        pd.power_off_req_i = 1'b1;
        pd.power_on_req_i  = 1'b1;
        model_req(c, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL both_req cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (cyc == c + 1) begin
                checks++;
                if (pd.clkgate_en_no !== 1'b0) begin
                    errors++;
                    $display("FAIL both_req_clk got %b exp 0",
                             pd.clkgate_en_no);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        ack_force = 1'b1;
        tick();
        c = cyc;
        pd.power_on_req_i = 1'b1;
        model_req(c, 1'b0, 1'b1);
        for (int k = 0; k < TO + 6; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL timeout_wait cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (cyc == c + TO || cyc == c + 1 + TO) begin
                checks++;
                if (pd.timeout_o !== (cyc == c + 1 + TO)) begin
                    errors++;
                    $display("FAIL timeout_edge cyc %0d got %b", cyc,
                             pd.timeout_o);
                end
            end
        end
        tick();
        ack_force = 1'b0;
        m_a = cyc;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL timeout_release cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
        end
        checks++;
        if (pd.timeout_o !== 1'b1 || pd.status_o !== STATUS_ON) begin
            errors++;
            $display("FAIL timeout_sticky got %b %b exp 1 00",
                     pd.timeout_o, pd.status_o);
        end
        tick();
        c = cyc;
        pd.power_off_req_i = 1'b1;
        model_req(c, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL timeout_clear cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit off, on;
        for (int k = 0; k < 2000; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            off = ($urandom_range(0, 9) == 0);
            on  = ($urandom_range(0, 9) == 0);
            pd.power_off_req_i = off;
            pd.power_on_req_i  = on;
            model_req(cyc, off, on);
        end
    endtask

    task automatic test_async_reset();
        int c;
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL settle cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
            if (k == 39 && model_off(cyc)) begin
                pd.power_on_req_i = 1'b1;
                model_req(cyc, 1'b0, 1'b1);
            end
        end
        repeat (30) tick();
        tick();
        c = cyc;
        pd.power_off_req_i = 1'b1;
        model_req(c, 1'b1, 1'b0);
        while (cyc < c + 1 + 3 * S + 4) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL pre_reset cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== RST_EXP) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", obs(), RST_EXP);
        end
        tick();
        rst_n = 1'b1;
        m_dir = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out(cyc)) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b exp %b",
                         cyc, obs(), exp_out(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_ignored();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
